// File: rtl/kogge_stone_pipe_if.sv
// Streaming handshake bundle for kogge_stone_pipe.
// Operand/result vectors are indexed [WIDTH:1] with bit 1 as the LSB.
// Optional build macro: KOGGE_STONE_PIPE_OVF_EN adds the registered ovf signal.
interface kogge_stone_pipe_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH:1] A;
  logic [WIDTH:1] B;
  logic           cin;
  logic           in_valid;
  logic           in_ready;
  logic [WIDTH:1] sum;
  logic           cout;
  logic           out_valid;
  logic           out_ready;
`ifdef KOGGE_STONE_PIPE_OVF_EN
  logic           ovf;
`endif

  // Producer/consumer side: supplies operands, accepts results.
  modport master (
    output A, B, cin, in_valid, out_ready,
`ifdef KOGGE_STONE_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, sum, cout, out_valid
  );

  // Adder side.
  modport slave (
    input  A, B, cin, in_valid, out_ready,
`ifdef KOGGE_STONE_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, sum, cout, out_valid
  );
endinterface

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone parallel-prefix adder with valid/ready streaming.
//   {cout,sum} = A + B + cin, latency = ceil(log2(WIDTH)/LEVELS_PER_STAGE) + 1.
// Stage 0 registers bitwise generate/propagate with cin folded in as the
// generate of a virtual bit 0. Each later stage evaluates LEVELS_PER_STAGE
// prefix rows (distances 1, 2, 4, ... WIDTH/2); the last stage may hold fewer.
// The output register forms the sum bits and the carry out. A single global
// advance enable stalls the whole pipe when the result is not taken.
// Optional build macro: KOGGE_STONE_PIPE_OVF_EN adds a registered signed
// overflow flag (carry into MSB xor carry out) on the interface.
module kogge_stone_pipe #(
  parameter int WIDTH            = 16,
  parameter int LEVELS_PER_STAGE = 2
) (
  input logic               clk,
  input logic               rst_n,
  kogge_stone_pipe_if.slave bus
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int NPS   = (LOG2W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Group generate/propagate vectors; bit 0 is the virtual cin position.
  typedef struct packed {
    logic [WIDTH:0] g;
    logic [WIDTH:0] p;
  } gp_t;

  // Last prefix row (exclusive) handled by stage s; clamps the final stage.
  function automatic int row_end(int s);
    return (s * LEVELS_PER_STAGE < LOG2W) ? s * LEVELS_PER_STAGE : LOG2W;
  endfunction

  // Evaluate prefix rows [first_row, last_row). Row r combines each node
  // with the node 2**r positions below it; lower nodes pass through.
  function automatic gp_t prefix_rows(gp_t gp_in, int first_row, int last_row);
    gp_t cur;
    gp_t nxt;
    cur = gp_in;
    for (int row = first_row; row < last_row; row++) begin
      nxt = cur;
      for (int i = 0; i <= WIDTH; i++) begin
        if (i >= (1 << row)) begin
          nxt.g[i] = cur.g[i] | (cur.p[i] & cur.g[i - (1 << row)]);
          nxt.p[i] = cur.p[i] & cur.p[i - (1 << row)];
        end
      end
      cur = nxt;
    end
    return cur;
  endfunction

  gp_t            gp_q   [NPS+1];
  gp_t            gp_d   [NPS+1];
  logic [WIDTH:1] praw_q [NPS+1];
  logic [NPS:0]   vld_q;

  logic           advance;
  logic [WIDTH:1] sum_q;
  logic [WIDTH:1] sum_d;
  logic           cout_q;
  logic           cout_d;
  logic           out_valid_q;
`ifdef KOGGE_STONE_PIPE_OVF_EN
  logic           ovf_q;
  logic           ovf_d;
`endif

  // The pipe moves only when the output slot is empty or being drained.
  assign advance = !out_valid_q || bus.out_ready;

  // Next-state (G,P) for every stage: bitwise setup, then prefix rows.
  // NOTE: every always_comb output gets a default before any conditional
  // logic so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int s = 0; s <= NPS; s++) gp_d[s] = '0;
    gp_d[0].g = {bus.A & bus.B, bus.cin};
    gp_d[0].p = {bus.A ^ bus.B, 1'b0};
    for (int s = 1; s <= NPS; s++) begin
      gp_d[s] = prefix_rows(gp_q[s-1], (s - 1) * LEVELS_PER_STAGE, row_end(s));
    end
  end

  // Prefix pipeline registers and valid bits; everything holds on a stall.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of code order.
  // The datapath registers are reset along with the valid bits so a reset
  // leaves no stale operand bits anywhere in the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s <= NPS; s++) begin
        gp_q[s]   <= '0;
        praw_q[s] <= '0;
      end
    end else if (advance) begin
      vld_q     <= {vld_q[NPS-1:0], bus.in_valid};
      praw_q[0] <= bus.A ^ bus.B;
      for (int s = 0; s <= NPS; s++) gp_q[s] <= gp_d[s];
      for (int s = 1; s <= NPS; s++) praw_q[s] <= praw_q[s-1];
    end
  end

  // Sum and carry from the completed prefix tree. After LOG2W rows node i
  // spans bits i..i-WIDTH+1, so nodes below WIDTH already reach the virtual
  // cin bit; the top node needs one more gray merge with bit 0 for cout.
  always_comb begin
    sum_d  = praw_q[NPS] ^ gp_q[NPS].g[WIDTH-1:0];
    cout_d = gp_q[NPS].g[WIDTH] | (gp_q[NPS].p[WIDTH] & gp_q[NPS].g[0]);
`ifdef KOGGE_STONE_PIPE_OVF_EN
    ovf_d  = gp_q[NPS].g[WIDTH-1] ^ cout_d;
`endif
  end

  // Output register: results load only for valid slots, so sum/cout keep
  // their last value across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef KOGGE_STONE_PIPE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else if (advance) begin
      out_valid_q <= vld_q[NPS];
      if (vld_q[NPS]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
`ifdef KOGGE_STONE_PIPE_OVF_EN
        ovf_q  <= ovf_d;
`endif
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef KOGGE_STONE_PIPE_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_kogge_stone_pipe.sv
// Self-checking bench for kogge_stone_pipe: directed table at WIDTH=16,
// streaming, stall and mid-operation reset sequences, plus streaming checks
// of WIDTH=4/LEVELS_PER_STAGE=1 and WIDTH=64/LEVELS_PER_STAGE=6 instances.
// Honours KOGGE_STONE_PIPE_OVF_EN when the ovf flag is built in.
module tb_kogge_stone_pipe;

  localparam int LAT16 = 3;
  localparam int NV    = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kogge_stone_pipe_if #(.WIDTH(16)) bus16 ();
  kogge_stone_pipe_if #(.WIDTH(4))  bus4  ();
  kogge_stone_pipe_if #(.WIDTH(64)) bus64 ();

  kogge_stone_pipe #(.WIDTH(16), .LEVELS_PER_STAGE(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
  );
  kogge_stone_pipe #(.WIDTH(4), .LEVELS_PER_STAGE(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );
  kogge_stone_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(6)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64.slave)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl [NV];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Move to 2 ns after the next rising edge; inputs are driven there and
  // outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(int sel, logic [63:0] a, logic [63:0] b, logic c,
                     logic v, logic r);
    case (sel)
      0: begin
        bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.cin = c;
        bus16.in_valid = v; bus16.out_ready = r;
      end
      1: begin
        bus4.A = a[3:0]; bus4.B = b[3:0]; bus4.cin = c;
        bus4.in_valid = v; bus4.out_ready = r;
      end
      default: begin
        bus64.A = a; bus64.B = b; bus64.cin = c;
        bus64.in_valid = v; bus64.out_ready = r;
      end
    endcase
  endtask

  function automatic logic [64:0] get_res(int sel);
    case (sel)
      0:       return {48'b0, bus16.cout, bus16.sum};
      1:       return {60'b0, bus4.cout, bus4.sum};
      default: return {bus64.cout, bus64.sum};
    endcase
  endfunction

  function automatic logic get_ovalid(int sel);
    case (sel)
      0:       return bus16.out_valid;
      1:       return bus4.out_valid;
      default: return bus64.out_valid;
    endcase
  endfunction

  function automatic logic get_iready(int sel);
    case (sel)
      0:       return bus16.in_ready;
      1:       return bus4.in_ready;
      default: return bus64.in_ready;
    endcase
  endfunction

  // One isolated operand on the 16-bit instance: exact latency, result
  // value, single-cycle out_valid and result retention afterwards.
  task automatic single_shot(vec_t v, string tag);
    put(0, 64'(v.a), 64'(v.b), v.cin, 1'b1, 1'b1);
    #1;
    check({tag, "_in_ready"}, 128'(bus16.in_ready), 128'(1));
    tick();
    bus16.in_valid = 1'b0;
    repeat (LAT16 - 1) tick();
    #1;
    check({tag, "_early_valid"}, 128'(bus16.out_valid), 128'(0));
    tick();
    #1;
    check({tag, "_valid"}, 128'(bus16.out_valid), 128'(1));
    check({tag, "_sum"},   128'(bus16.sum),       128'(v.sum));
    check({tag, "_cout"},  128'(bus16.cout),      128'(v.cout));
`ifdef KOGGE_STONE_PIPE_OVF_EN
    check({tag, "_ovf"},   128'(bus16.ovf),       128'(v.ovf));
`endif
    tick();
    #1;
    check({tag, "_late_valid"}, 128'(bus16.out_valid), 128'(0));
    check({tag, "_sum_held"},   128'(bus16.sum),       128'(v.sum));
  endtask

  // Random operand stream with a scoreboard queue; an optional out_ready
  // low window checks in_ready, frozen outputs and no loss/duplication.
  task automatic stream(int sel, int n, int stall_start, int stall_len, string tag);
    logic [64:0]  q[$];
    logic [63:0]  mask;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         c;
    logic [127:0] snap;
    logic         stalled;
    int           w;
    int           idx = 0;
    int           cyc = 0;
    int           got = 0;
    int           first = -1;
    int           last = -1;
    int           rdy_low = 0;

    w    = (sel == 0) ? 16 : ((sel == 1) ? 4 : 64);
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    snap = '0;
    a = {$urandom(), $urandom()} & mask;
    b = {$urandom(), $urandom()} & mask;
    c = 1'($urandom_range(1));
    while ((idx < n || q.size() != 0) && cyc < 400) begin
      stalled = (cyc >= stall_start) && (cyc < stall_start + stall_len);
      put(sel, a, b, c, idx < n, !stalled);
      #1;
      if (stalled) begin
        check({tag, "_ready_low"}, 128'(get_iready(sel)), 128'(0));
        if (cyc == stall_start) snap = {62'b0, get_ovalid(sel), get_res(sel)};
        else check({tag, "_frozen"}, {62'b0, get_ovalid(sel), get_res(sel)}, snap);
      end else if (!get_iready(sel)) begin
        rdy_low++;
      end
      if (get_ovalid(sel) && !stalled) begin
        check({tag, "_have_expect"}, 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) check({tag, "_result"}, 128'(get_res(sel)), 128'(q.pop_front()));
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (idx < n && get_iready(sel)) begin
        q.push_back(65'(a) + 65'(b) + 65'(c));
        idx++;
        a = {$urandom(), $urandom()} & mask;
        b = {$urandom(), $urandom()} & mask;
        c = 1'($urandom_range(1));
      end
      tick();
      cyc++;
    end
    put(sel, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    check({tag, "_completed"}, 128'(cyc < 400), 128'(1));
    check({tag, "_count"},     128'(got),       128'(n));
    if (stall_len == 0) begin
      check({tag, "_ready_high"},  128'(rdy_low),          128'(0));
      check({tag, "_consecutive"}, 128'(last - first + 1), 128'(n));
    end
  endtask

  // Three operands in flight, asynchronous reset mid-cycle, then release.
  task automatic mid_reset();
    int highs = 0;
    put(0, 64'hFFFF, 64'h0003, 1'b0, 1'b1, 1'b1); tick();
    put(0, 64'h0F0F, 64'h0101, 1'b1, 1'b1, 1'b1); tick();
    put(0, 64'h1234, 64'h4321, 1'b0, 1'b1, 1'b1); tick();
    put(0, 64'h0000, 64'h0000, 1'b0, 1'b0, 1'b1); tick();
    #1;
    check("rst_pre_valid", 128'(bus16.out_valid), 128'(1));
    check("rst_pre_sum",   128'(bus16.sum),       128'(16'h0002));
    check("rst_pre_cout",  128'(bus16.cout),      128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 128'(bus16.out_valid), 128'(0));
    check("rst_async_sum",   128'(bus16.sum),       128'(0));
    check("rst_async_cout",  128'(bus16.cout),      128'(0));
    check("rst_async_ready", 128'(bus16.in_ready),  128'(1));
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    repeat (6) begin
      #1;
      highs += int'(bus16.out_valid);
      tick();
    end
    check("rst_no_stale", 128'(highs), 128'(0));
    single_shot(tbl[6], "rst_first");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             a         b         cin   sum       cout  ovf
    tbl[0]  = '{16'h0003, 16'h0006, 1'b0, 16'h0009, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[6]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[7]  = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[9]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[10] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    put(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    put(1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    put(2, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_valid", 128'(bus16.out_valid), 128'(0));
    check("reset_sum",   128'(bus16.sum),       128'(0));
    check("reset_cout",  128'(bus16.cout),      128'(0));
    check("reset_ready", 128'(bus16.in_ready),  128'(1));
`ifdef KOGGE_STONE_PIPE_OVF_EN
    check("reset_ovf",   128'(bus16.ovf),       128'(0));
`endif
    #6 rst_n = 1'b1;
    put(1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    put(2, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    tick();

    for (int i = 0; i < NV; i++) single_shot(tbl[i], $sformatf("vec%0d", i));

    stream(0, 20, 0, 0, "w16_stream");
    stream(0, 12, 5, 5, "w16_stall");
    mid_reset();
    stream(1, 20, 0, 0, "w4_stream");
    stream(2, 20, 0, 0, "w64_stream");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
